// File: rtl/stream_demux_1ton.sv
// ============================================================================
// Module      : stream_demux_1ton
// Description : 1-to-N valid/ready stream demultiplexer with explicit-select
//               and round-robin routing, one registered entry per channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1ton #(
    parameter int DATA_W = 5,
    parameter int N_CH   = 4,
    parameter int SEL_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]         rr_ptr,
    output logic [7:0]               drop_cnt
);

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0]       w_tgt;
    logic                   w_tgt_ok;
    logic                   w_slot_free;
    logic                   w_in_ready;
    logic                   w_accept;

    logic [N_CH-1:0]        r_valid;
    logic [N_CH*DATA_W-1:0] r_data;
    logic [SEL_W-1:0]       r_rr;
    logic [7:0]             r_drop;

    // Scan channels instead of indexing r_valid[w_tgt]: an explicit select can
    // exceed N_CH-1 when N_CH is not a power of two.
    always_comb begin
        w_tgt       = mode ? r_rr : sel;
        w_tgt_ok    = 1'b0;
        w_slot_free = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_tgt == SEL_W'(i)) begin
                w_tgt_ok    = 1'b1;
                w_slot_free = !r_valid[i] || out_ready[i];
            end
        end
    end

    assign w_in_ready = !rst && (!w_tgt_ok || w_slot_free);
    assign w_accept   = in_valid && w_in_ready;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic w_load;
            assign w_load = w_accept && (w_tgt == SEL_W'(i));

            // A reload in the same cycle as a pop replaces the entry with no bubble.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[i]                  <= 1'b0;
                    r_data[i*DATA_W +: DATA_W]  <= '0;
                end else if (w_load) begin
                    r_valid[i]                  <= 1'b1;
                    r_data[i*DATA_W +: DATA_W]  <= in_data;
                end else if (r_valid[i] && out_ready[i]) begin
                    r_valid[i]                  <= 1'b0;
                    r_data[i*DATA_W +: DATA_W]  <= '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_accept && mode) begin
            r_rr <= (r_rr == c_last_ch) ? '0 : r_rr + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 8'd0;
        end else if (w_accept && !w_tgt_ok && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign rr_ptr    = r_rr;
    assign drop_cnt  = r_drop;

endmodule

`default_nettype wire
